// File: rtl/regbank_sequencer.sv
// rtl/regbank_sequencer.sv - single-issue ALU sequencer driving a 32x32 register bank
//
// Purpose:
//   Accepts one 32-bit instruction per handshake, reads both source operands
//   from the register bank, computes an ALU result and issues one write back.
//   Each instruction walks IDLE -> READ -> EXEC -> WB -> IDLE, so the block
//   retires at most one instruction every 4 cycles.
//
// Instruction word:
//   [31:28] op, [27:23] dr, [22:18] sr1, [17:13] sr2, [12:0] imm13 (signed)
//   op 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 ADDI, 8 SLT,
//   9..15 illegal (result 0, no write).
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high
//   instr_valid_i  in   instruction offered
//   instr_i        in   instruction word, held by the source until accepted
//   instr_ready_o  out  high only in IDLE
//   sr1_o, sr2_o   out  bank read addresses
//   regd1_i,
//   regd2_i        in   bank read data (combinational from sr1_o/sr2_o)
//   dr_o           out  bank write address
//   wdata_o        out  bank write data
//   write_o        out  bank write enable, asserted only in WB
//   done_o         out  one-cycle retire pulse (WB)
//   illegal_o      out  qualifies done_o: op was undefined
//   result_o       out  ALU result, held until the next retire
//
// Configuration:
//   ZERO_REG_EN    when defined, writes to r0 are suppressed so r0 stays 0;
//                  done_o still pulses and result_o still updates.
//
// Every output is a flop; nothing passes combinationally from inputs to outputs.

module regbank_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  output logic [4:0]  sr1_o,
  output logic [4:0]  sr2_o,
  input  logic [31:0] regd1_i,
  input  logic [31:0] regd2_i,
  output logic [4:0]  dr_o,
  output logic [31:0] wdata_o,
  output logic        write_o,
  output logic        done_o,
  output logic        illegal_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [12:0] imm_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [4:0]  sr1_q;
  logic [4:0]  sr2_q;
  logic [4:0]  dr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        done_q;
  logic        illegal_q;
  logic [31:0] result_q;
  logic        ready_q;

  logic [31:0] imm_sext;
  logic [31:0] alu_d;
  logic        illegal_d;
  logic        write_d;

  // ALU operates on the operand registers captured in READ.
  always_comb begin
    imm_sext  = {{19{imm_q[12]}}, imm_q};
    alu_d     = 32'd0;
    illegal_d = 1'b0;
    case (op_q)
      OP_ADD:  alu_d = opa_q + opb_q;
      OP_SUB:  alu_d = opa_q - opb_q;
      OP_AND:  alu_d = opa_q & opb_q;
      OP_OR:   alu_d = opa_q | opb_q;
      OP_XOR:  alu_d = opa_q ^ opb_q;
      OP_SLL:  alu_d = opa_q << opb_q[4:0];
      OP_SRL:  alu_d = opa_q >> opb_q[4:0];
      OP_ADDI: alu_d = opa_q + imm_sext;
      OP_SLT:  alu_d = {31'd0, ($signed(opa_q) < $signed(opb_q))};
      default: begin
        alu_d     = 32'd0;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Write-enable decision for the coming WB cycle.
  always_comb begin
`ifdef ZERO_REG_EN
    write_d = !illegal_d && (dr_q != 5'd0);
`else
    write_d = !illegal_d;
`endif
  end

  // Single FSM block; every output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      imm_q     <= 13'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      sr1_q     <= 5'd0;
      sr2_q     <= 5'd0;
      dr_q      <= 5'd0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 32'd0;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid_i && ready_q) begin
            // Addresses are taken straight from the offered word so the
            // bank read data is already valid throughout READ.
            op_q    <= instr_i[31:28];
            dr_q    <= instr_i[27:23];
            sr1_q   <= instr_i[22:18];
            sr2_q   <= instr_i[17:13];
            imm_q   <= instr_i[12:0];
            ready_q <= 1'b0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          opa_q   <= regd1_i;
          opb_q   <= regd2_i;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q  <= alu_d;
          wdata_q   <= alu_d;
          illegal_q <= illegal_d;
          write_q   <= write_d;
          done_q    <= 1'b1;
          state_q   <= S_WB;
        end
        S_WB: begin
          // The bank takes the write at this edge; the block is free again.
          write_q   <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign sr1_o         = sr1_q;
  assign sr2_o         = sr2_q;
  assign dr_o          = dr_q;
  assign wdata_o       = wdata_q;
  assign write_o       = write_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
  assign result_o      = result_q;

endmodule
